// File: rtl/l1_data_cache_pkg.sv
// Shared geometry, width helpers and FSM state type for the L1 data cache.
package cache_types;

    localparam int unsigned S_OFFSET    = 5;
    localparam int unsigned LINE_W      = 256;
    localparam int unsigned LINE_BYTES  = LINE_W / 8;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned S_INDEX_DEF = 4;

    function automatic int unsigned tag_width(input int unsigned s_index);
        return ADDR_W - S_OFFSET - s_index;
    endfunction

    function automatic int unsigned num_sets(input int unsigned s_index);
        return 32'd1 << s_index;
    endfunction

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_t;

endpackage

// File: rtl/l1_data_cache_way.sv
// One cache way: valid/dirty bits with reset, tag and line storage with byte-masked writes.
module cache_way
    import cache_types::*;
#(
    parameter  int unsigned S_INDEX = S_INDEX_DEF,
    localparam int unsigned TAG_W   = tag_width(S_INDEX)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [S_INDEX-1:0]    index,
    input  logic [LINE_BYTES-1:0] data_we,
    input  logic [LINE_W-1:0]     wdata,
    input  logic                  tag_we,
    input  logic [TAG_W-1:0]      tag_in,
    input  logic                  set_valid,
    input  logic                  set_dirty,
    input  logic                  clr_dirty,
    output logic                  valid,
    output logic                  dirty,
    output logic [TAG_W-1:0]      tag,
    output logic [LINE_W-1:0]     data
);

    localparam int unsigned SETS = num_sets(S_INDEX);

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (set_valid) valid_q[index] <= 1'b1;
            if (clr_dirty) dirty_q[index] <= 1'b0;
            else if (set_dirty) dirty_q[index] <= 1'b1;
        end
    end

    // Tag and data contents need no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (tag_we) tag_q[index] <= tag_in;
        for (int b = 0; b < int'(LINE_BYTES); b++) begin
            if (data_we[b]) data_q[index][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    assign valid = valid_q[index];
    assign dirty = dirty_q[index];
    assign tag   = tag_q[index];
    assign data  = data_q[index];

endmodule

// File: rtl/l1_data_cache.sv
// Two-way set-associative write-back, write-allocate L1 data cache with 256-bit line fills.
module l1_data_cache
    import cache_types::*;
#(
    parameter int unsigned S_INDEX = S_INDEX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [3:0]        mem_byte_enable,
    input  logic [31:0]       mem_address,
    input  logic [31:0]       mem_wdata,
    output logic              mem_resp,
    output logic [31:0]       mem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    localparam int unsigned TAG_W = tag_width(S_INDEX);
    localparam int unsigned SETS  = num_sets(S_INDEX);

    cache_state_t       state;
    logic [SETS-1:0]    lru;
    logic               victim_q;
    logic [S_INDEX-1:0] miss_index;
    logic [TAG_W-1:0]   miss_tag;

    logic [S_INDEX-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [2:0]         word_sel;
    logic [S_INDEX-1:0] index;
    logic               req;
    logic               hit_resp;
    logic               hit_way;
    logic               victim_c;
    logic [LINE_BYTES-1:0] byte_mask;
    logic [LINE_W-1:0]  line_wdata;
    logic               unused_addr;

    logic [1:0]                   way_valid;
    logic [1:0]                   way_dirty;
    logic [1:0]                   way_hit;
    logic [1:0][TAG_W-1:0]        way_tag;
    logic [1:0][LINE_W-1:0]       way_data;
    logic [1:0][LINE_BYTES-1:0]   way_data_we;
    logic [1:0]                   way_tag_we;
    logic [1:0]                   way_set_valid;
    logic [1:0]                   way_set_dirty;
    logic [1:0]                   way_clr_dirty;

    assign req_index   = mem_address[S_OFFSET +: S_INDEX];
    assign req_tag     = mem_address[ADDR_W-1 -: TAG_W];
    assign word_sel    = mem_address[4:2];
    assign unused_addr = ^mem_address[1:0];
    assign req         = mem_read | mem_write;

    // During a miss the arrays stay pointed at the latched set so pmem_address holds still.
    assign index = (state == IDLE) ? req_index : miss_index;

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way #(.S_INDEX(S_INDEX)) u_way (
            .clk       (clk),
            .rst       (rst),
            .index     (index),
            .data_we   (way_data_we[w]),
            .wdata     (line_wdata),
            .tag_we    (way_tag_we[w]),
            .tag_in    (miss_tag),
            .set_valid (way_set_valid[w]),
            .set_dirty (way_set_dirty[w]),
            .clr_dirty (way_clr_dirty[w]),
            .valid     (way_valid[w]),
            .dirty     (way_dirty[w]),
            .tag       (way_tag[w]),
            .data      (way_data[w])
        );
        assign way_hit[w] = way_valid[w] && (way_tag[w] == req_tag);
    end

    assign hit_resp  = !rst && (state == IDLE) && req && (|way_hit);
    assign hit_way   = way_hit[1];
    assign victim_c  = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru[req_index]);
    assign byte_mask = LINE_BYTES'(mem_byte_enable) << {word_sel, 2'b00};
    assign line_wdata = (state == ALLOCATE) ? pmem_rdata : {8{mem_wdata}};

    // Array write strobes: write-hit merge, writeback dirty clear, line fill.
    always_comb begin
        for (int w = 0; w < 2; w++) begin
            way_data_we[w]   = '0;
            way_tag_we[w]    = 1'b0;
            way_set_valid[w] = 1'b0;
            way_set_dirty[w] = 1'b0;
            way_clr_dirty[w] = 1'b0;
            if (hit_resp && mem_write && (hit_way == 1'(w))) begin
                way_data_we[w]   = byte_mask;
                way_set_dirty[w] = 1'b1;
            end
            if ((state == WRITEBACK) && pmem_resp && (victim_q == 1'(w))) begin
                way_clr_dirty[w] = 1'b1;
            end
            if ((state == ALLOCATE) && pmem_resp && (victim_q == 1'(w))) begin
                way_data_we[w]   = '1;
                way_tag_we[w]    = 1'b1;
                way_set_valid[w] = 1'b1;
                way_clr_dirty[w] = 1'b1;
            end
        end
    end

    always_comb begin
        mem_resp     = hit_resp;
        mem_rdata    = '0;
        pmem_read    = (state == ALLOCATE);
        pmem_write   = (state == WRITEBACK);
        pmem_address = '0;
        pmem_wdata   = '0;
        if (hit_resp && !mem_write) mem_rdata = way_data[hit_way][{word_sel, 5'b00000} +: WORD_W];
        if (state == WRITEBACK) begin
            pmem_address = {way_tag[victim_q], miss_index, 5'b00000};
            pmem_wdata   = way_data[victim_q];
        end else if (state == ALLOCATE) begin
            pmem_address = {miss_tag, miss_index, 5'b00000};
        end
    end

    // Miss FSM and LRU; the victim and request set/tag are latched on the miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lru        <= '0;
            victim_q   <= 1'b0;
            miss_index <= '0;
            miss_tag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit_resp) begin
                        lru[req_index] <= ~hit_way;
                    end else if (req) begin
                        victim_q   <= victim_c;
                        miss_index <= req_index;
                        miss_tag   <= req_tag;
                        state      <= (way_valid[victim_c] && way_dirty[victim_c]) ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: if (pmem_resp) state <= ALLOCATE;
                ALLOCATE:  if (pmem_resp) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(mem_read && mem_write))
                else $error("l1_data_cache: mem_read and mem_write asserted together");
        end
    end

endmodule
